alu_arbiter: RTL and testbench

//  Shares one ALU instance (N-bit, 3-bit opcode, 4-bit flags) between two requesters.

---
 rtl/alu_defs.sv | 13 +
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// ALU opcode encoding shared by the ALU and its clients.
package alu_defs;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] AND_ = 3'd2;
  localparam logic [2:0] OR_  = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4;
  localparam logic [2:0] NOT_ = 3'd5;
  localparam logic [2:0] SHL  = 3'd6;
  localparam logic [2:0] SHR  = 3'd7;

endpackage

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared N-bit ALU.
// One operation in flight: IDLE accepts, EXEC computes, RESP holds the result
// until the owning requester takes it.
module alu_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [N-1:0] req0_a_i,
  input  logic [N-1:0] req0_b_i,
  input  logic [2:0]   req0_op_i,
  input  logic [N-1:0] req1_a_i,
  input  logic [N-1:0] req1_b_i,
  input  logic [2:0]   req1_op_i,
  output logic [1:0]   rsp_valid_o,
  input  logic [1:0]   rsp_ready_i,
  output logic [N-1:0] rsp_result_o,
  output logic [3:0]   rsp_flags_o,
  output logic         rsp_owner_o,
  output logic         busy_o
);

  import alu_defs::*;

  localparam int unsigned W = N + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic         ptr_q;
  logic         owner_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [2:0]   op_q;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;
  logic [1:0]   rsp_valid_q;
  logic         busy_q;

  logic         any_valid_c;
  logic         grant_c;
  logic         req_fire_c;
  logic         rsp_fire_c;
  logic [N-1:0] b_eff_c;
  logic [W-1:0] sum_c;
  logic         carry_c;
  logic         ovf_c;
  logic [N-1:0] alu_result_c;
  logic [3:0]   alu_flags_c;

  // Round-robin grant: a lone requester wins outright, a tie goes to ptr.
  always_comb begin
    any_valid_c = |req_valid_i;
    grant_c     = (req_valid_i == 2'b11) ? ptr_q : req_valid_i[1];
  end

  // In IDLE the granted requester always has valid high, so grant implies handshake.
  assign req_fire_c  = (state_q == S_IDLE) && any_valid_c;
  assign rsp_fire_c  = (state_q == S_RESP) && rsp_ready_i[owner_q];
  assign req_ready_o = (req_fire_c && rst_n_i) ? (2'b01 << grant_c) : 2'b00;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_fire_c) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_fire_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shared ALU, driven from the latched operands; SUB reuses the adder as a + ~b + 1.
  always_comb begin
    b_eff_c      = (op_q == SUB) ? ~b_q : b_q;
    sum_c        = {1'b0, a_q} + {1'b0, b_eff_c} + W'(op_q == SUB);
    alu_result_c = '0;
    carry_c      = 1'b0;
    ovf_c        = 1'b0;
    case (op_q)
      ADD, SUB: begin
        alu_result_c = sum_c[N-1:0];
        carry_c      = sum_c[N];
        ovf_c        = (a_q[N-1] == b_eff_c[N-1]) && (sum_c[N-1] != a_q[N-1]);
      end
      AND_:    alu_result_c = a_q & b_q;
      OR_:     alu_result_c = a_q | b_q;
      XOR_:    alu_result_c = a_q ^ b_q;
      NOT_:    alu_result_c = ~a_q;
      SHL:     alu_result_c = a_q << 1;
      SHR:     alu_result_c = a_q >> 1;
      default: alu_result_c = '0;
    endcase
    alu_flags_c = {alu_result_c[N-1], (alu_result_c == '0), carry_c, ovf_c};
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Operand capture, response registers and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (req_fire_c) begin
        owner_q <= grant_c;
        a_q     <= grant_c ? req1_a_i  : req0_a_i;
        b_q     <= grant_c ? req1_b_i  : req0_b_i;
        op_q    <= grant_c ? req1_op_i : req0_op_i;
      end
      if (state_q == S_EXEC) begin
        result_q    <= alu_result_c;
        flags_q     <= alu_flags_c;
        rsp_valid_q <= 2'b01 << owner_q;
      end
      if (rsp_fire_c) begin
        rsp_valid_q <= '0;
        ptr_q       <= ~owner_q;
      end
      busy_q <= (state_d != S_IDLE);
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign rsp_flags_o  = flags_q;
  assign rsp_owner_o  = owner_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (N=4): expected responses are queued at
// the request handshake and popped when the DUT presents a response.
module tb_alu_arbiter;

  import alu_defs::*;

  typedef struct packed {
    logic [1:0] valid;
    logic       owner;
    logic [3:0] result;
    logic [3:0] flags;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [1:0] req_valid_i;
  logic [1:0] req_ready_o;
  logic [3:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic [2:0] req0_op_i, req1_op_i;
  logic [1:0] rsp_valid_o;
  logic [1:0] rsp_ready_i;
  logic [3:0] rsp_result_o;
  logic [3:0] rsp_flags_o;
  logic       rsp_owner_o;
  logic       busy_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  alu_arbiter #(.N(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_op_i(req0_op_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_op_i(req1_op_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o),
    .rsp_owner_o(rsp_owner_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference ALU built on plain integer arithmetic; returns {result, flags}.
  function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb_s, r, s;
    logic c, v;
    logic [3:0] r4;
    ua = int'(a); ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb_s = b[3] ? ub - 16 : ub;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      ADD: begin r = ua + ub; c = (r > 15); s = sa + sb_s; v = (s > 7) || (s < -8); end
      SUB: begin r = ua - ub; c = (ua >= ub); s = sa - sb_s; v = (s > 7) || (s < -8); end
      AND_: r = ua & ub;
      OR_:  r = ua | ub;
      XOR_: r = ua ^ ub;
      NOT_: r = 15 - ua;
      SHL:  r = ua * 2;
      SHR:  r = ua / 2;
      default: r = 0;
    endcase
    r4 = 4'(r & 15);
    return {r4, r4[3], (r4 == 4'd0), c, v};
  endfunction

  function automatic exp_t mk_exp(input int idx, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    exp_t e;
    logic [7:0] m;
    m = model(op, a, b);
    e.valid  = (idx == 0) ? 2'b01 : 2'b10;
    e.owner  = 1'(idx);
    e.result = m[7:4];
    e.flags  = m[3:0];
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    if (sb.size() != 0) e = sb.pop_front();
    else e = '0;
    return e;
  endfunction

  function automatic exp_t cur_rsp();
    return {rsp_valid_o, rsp_owner_o, rsp_result_o, rsp_flags_o};
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0; req_valid_i = 2'b00; rsp_ready_i = 2'b00;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Present one request from requester idx; returns just after its handshake edge.
  task automatic send(input int idx, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] op, output bit ok);
    ok = 1'b0;
    @(negedge clk_i);
    if (idx == 0) begin req0_a_i = a; req0_b_i = b; req0_op_i = op; end
    else          begin req1_a_i = a; req1_b_i = b; req1_op_i = op; end
    req_valid_i[idx] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready_o[idx]) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    if (ok) begin
      sb.push_back(mk_exp(idx, a, b, op));
      @(posedge clk_i); #1;
    end
    req_valid_i[idx] = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (|rsp_valid_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic accept(input int idx);
    rsp_ready_i[idx] = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 2'b00;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; req_valid_i = 2'b11; rsp_ready_i = 2'b00;
    req0_a_i = '0; req0_b_i = '0; req0_op_i = '0;
    req1_a_i = '0; req1_b_i = '0; req1_op_i = '0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_owner_o, busy_o} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b val=%b res=%h flg=%b own=%b busy=%b want all 0",
               req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_owner_o, busy_o);
    end
    req_valid_i = 2'b00;
    rst_n_i = 1'b1;
  endtask

  task automatic test_add();
    bit ok;
    exp_t e;
    send(0, 4'h7, 4'h9, ADD, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL add_handshake got no grant want grant"); end
    @(negedge clk_i);
    n_checks++;
    if ({rsp_valid_o, busy_o} !== 3'b001) begin
      n_fail++; $display("FAIL add_exec_cycle got val=%b busy=%b want val=00 busy=1", rsp_valid_o, busy_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (cur_rsp() !== exp_t'({2'b01, 1'b0, 4'h0, 4'b0110})) begin
      n_fail++; $display("FAIL add_spec_rsp got %h want %h", cur_rsp(), exp_t'({2'b01, 1'b0, 4'h0, 4'b0110}));
    end
    e = pop_exp();
    n_checks++;
    if (cur_rsp() !== e) begin n_fail++; $display("FAIL add_scoreboard got %h want %h", cur_rsp(), e); end
    accept(0);
  endtask

  task automatic test_or();
    bit ok;
    exp_t e;
    send(1, 4'hA, 4'h5, OR_, ok);
    wait_rsp(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL or_timeout got no response want response"); end
    n_checks++;
    if (cur_rsp() !== exp_t'({2'b10, 1'b1, 4'hF, 4'b1000})) begin
      n_fail++; $display("FAIL or_spec_rsp got %h want %h", cur_rsp(), exp_t'({2'b10, 1'b1, 4'hF, 4'b1000}));
    end
    e = pop_exp();
    n_checks++;
    if (cur_rsp() !== e) begin n_fail++; $display("FAIL or_scoreboard got %h want %h", cur_rsp(), e); end
    accept(1);
  endtask

  task automatic test_fairness();
    bit ok;
    int g;
    exp_t e;
    logic [1:0] want;
    do_reset();
    @(negedge clk_i);
    req0_a_i = 4'($urandom); req0_b_i = 4'($urandom); req0_op_i = 3'($urandom);
    req1_a_i = 4'($urandom); req1_b_i = 4'($urandom); req1_op_i = 3'($urandom);
    req_valid_i = 2'b11; rsp_ready_i = 2'b11;
    for (int k = 0; k < 6; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        #1;
        if (req_ready_o != 2'b00) begin ok = 1'b1; break; end
        @(negedge clk_i);
      end
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if (!ok || req_ready_o !== want) begin
        n_fail++; $display("FAIL fair_grant_%0d got %b want %b", k, req_ready_o, want);
      end
      g = req_ready_o[1] ? 1 : 0;
      if (g == 0) sb.push_back(mk_exp(0, req0_a_i, req0_b_i, req0_op_i));
      else        sb.push_back(mk_exp(1, req1_a_i, req1_b_i, req1_op_i));
      @(posedge clk_i); #1;
      if (g == 0) begin req0_a_i = 4'($urandom); req0_b_i = 4'($urandom); req0_op_i = 3'($urandom); end
      else        begin req1_a_i = 4'($urandom); req1_b_i = 4'($urandom); req1_op_i = 3'($urandom); end
      wait_rsp(ok);
      e = pop_exp();
      n_checks++;
      if (!ok || cur_rsp() !== e) begin n_fail++; $display("FAIL fair_rsp_%0d got %h want %h", k, cur_rsp(), e); end
    end
    req_valid_i = 2'b00;
    @(posedge clk_i); #1;
    rsp_ready_i = 2'b00;
  endtask

  task automatic test_backpressure();
    bit ok;
    exp_t e;
    send(0, 4'h3, 4'h5, SUB, ok);
    wait_rsp(ok);
    e = pop_exp();
    n_checks++;
    if (!ok || cur_rsp() !== e) begin n_fail++; $display("FAIL bp_first_rsp got %h want %h", cur_rsp(), e); end
    req1_a_i = 4'hC; req1_b_i = 4'h6; req1_op_i = XOR_;
    req_valid_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({cur_rsp(), req_ready_o, busy_o} !== {e, 2'b00, 1'b1}) begin
        n_fail++; $display("FAIL bp_hold_%0d got rsp=%h rdy=%b busy=%b want rsp=%h rdy=00 busy=1",
                           i, cur_rsp(), req_ready_o, busy_o, e);
      end
      @(negedge clk_i);
    end
    rsp_ready_i = 2'b10;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      n_checks++;
      if ({cur_rsp(), req_ready_o} !== {e, 2'b00}) begin
        n_fail++; $display("FAIL bp_nonowner_%0d got rsp=%h rdy=%b want rsp=%h rdy=00", i, cur_rsp(), req_ready_o, e);
      end
    end
    rsp_ready_i = 2'b01;
    @(posedge clk_i); #1;
    rsp_ready_i = 2'b00;
    n_checks++;
    if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant got %b want 10", req_ready_o); end
    sb.push_back(mk_exp(1, req1_a_i, req1_b_i, req1_op_i));
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    wait_rsp(ok);
    e = pop_exp();
    n_checks++;
    if (!ok || cur_rsp() !== e) begin n_fail++; $display("FAIL bp_second_rsp got %h want %h", cur_rsp(), e); end
    accept(1);
  endtask

  task automatic test_reset_exec();
    bit ok;
    bit seen;
    exp_t e;
    send(0, 4'h2, 4'h3, ADD, ok);
    rst_n_i = 1'b0;
    #1;
    n_checks++;
    if ({req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_owner_o, busy_o} !== 14'd0) begin
      n_fail++; $display("FAIL rst_exec_outputs got rdy=%b val=%b res=%h flg=%b own=%b busy=%b want all 0",
                         req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_owner_o, busy_o);
    end
    sb.delete();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o != 2'b00 || busy_o) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL rst_exec_stale got stale response/busy want none"); end
    req0_a_i = 4'h8; req0_b_i = 4'h8; req0_op_i = ADD;
    req1_a_i = 4'h1; req1_b_i = 4'h1; req1_op_i = ADD;
    req_valid_i = 2'b11;
    #1;
    n_checks++;
    if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL rst_exec_ptr got %b want 01", req_ready_o); end
    sb.push_back(mk_exp(0, req0_a_i, req0_b_i, req0_op_i));
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    wait_rsp(ok);
    e = pop_exp();
    n_checks++;
    if (!ok || cur_rsp() !== e) begin n_fail++; $display("FAIL rst_exec_rsp got %h want %h", cur_rsp(), e); end
    accept(0);
  endtask

  task automatic test_idle_single();
    exp_t e;
    do_reset();
    @(negedge clk_i);
    #1;
    n_checks++;
    if ({req_ready_o, busy_o} !== 3'b000) begin
      n_fail++; $display("FAIL idle_quiet got rdy=%b busy=%b want 00 0", req_ready_o, busy_o);
    end
    req1_a_i = 4'h4; req1_b_i = 4'h0; req1_op_i = SHL;
    req_valid_i = 2'b10;
    #1;
    n_checks++;
    if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL idle_single_grant got %b want 10", req_ready_o); end
    sb.push_back(mk_exp(1, req1_a_i, req1_b_i, req1_op_i));
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    @(negedge clk_i);
    @(negedge clk_i);
    e = pop_exp();
    n_checks++;
    if (cur_rsp() !== e) begin n_fail++; $display("FAIL idle_single_rsp got %h want %h", cur_rsp(), e); end
    accept(1);
  endtask

  task automatic test_random();
    bit ok;
    int idx;
    exp_t e;
    for (int k = 0; k < 24; k++) begin
      idx = int'($urandom_range(0, 1));
      send(idx, 4'($urandom), 4'($urandom), 3'(k % 8), ok);
      wait_rsp(ok);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      e = pop_exp();
      n_checks++;
      if (!ok || cur_rsp() !== e) begin n_fail++; $display("FAIL random_%0d got %h want %h", k, cur_rsp(), e); end
      accept(idx);
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_or();
    test_fairness();
    test_backpressure();
    test_reset_exec();
    test_idle_single();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
